// File: rtl/n101_subsys_ahb_bpty_chk.sv
// rtl/n101_subsys_ahb_bpty_chk.sv - inbound AHB command/address/write-data byte-parity checker
// Optional error counter built only when N101_BPTY_CHK_ERRCNT_EN is defined.
module n101_subsys_ahb_bpty_chk #(
  parameter int ADDR_SIZE = 32,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 bptylvl,
  input  logic [1:0]           htrans,
  input  logic [2:0]           hsize,
  input  logic [2:0]           hburst,
  input  logic [3:0]           hprot,
  input  logic                 hwrite,
  input  logic                 hmastlock,
  input  logic [1:0]           master,
  input  logic [ADDR_SIZE-1:0] haddr,
  input  logic [31:0]          hwdata,
  input  logic                 hready,
  input  logic [1:0]           hcmdbpty,
  input  logic [3:0]           haddrbpty,
  input  logic [3:0]           hwdatabpty,
  input  logic                 err_clr,
  output logic                 bpty_err,
  output logic [2:0]           bpty_err_type,
  output logic [ADDR_SIZE-1:0] bpty_err_addr,
  output logic [ERR_CNT_W-1:0] bpty_err_cnt,
  output logic                 bpty_fatal
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_WDATA = 1'b1;

  logic [0:0]           state_q, state_d;
  logic [2:0]           size_q, size_d;
  logic [1:0]           lane_q, lane_d;
  logic [ADDR_SIZE-1:0] dph_addr_q, dph_addr_d;
  logic                 err_q, err_d;
  logic [2:0]           err_type_q, err_type_d;
  logic [ADDR_SIZE-1:0] err_addr_q, err_addr_d;
  logic                 fatal_q, fatal_d;

  logic [31:0] addr_pad;
  logic [3:0]  exp_addr, exp_wdata, lane_mask;
  logic        exp_cmd0, exp_cmd1;
  logic        addr_acc, write_acc;
  logic        cmd_err, addr_err, wdata_err, err_cyc;

  // Narrow addresses are zero-padded so byte parity always spans four bytes.
  always_comb begin
    addr_pad = '0;
    addr_pad[ADDR_SIZE-1:0] = haddr;
    for (int i = 0; i < 4; i++) begin
      exp_addr[i]  = (^addr_pad[8*i +: 8]) ^ bptylvl;
      exp_wdata[i] = (^hwdata[8*i +: 8]) ^ bptylvl;
    end
    exp_cmd0 = (^{htrans, hsize, hburst}) ^ bptylvl;
    exp_cmd1 = (^{hprot, hwrite, hmastlock, master}) ^ bptylvl;
  end

  always_comb begin
    lane_mask = 4'b1111;
    if (size_q == 3'd0) begin
      lane_mask = 4'b0001 << lane_q;
    end else if (size_q == 3'd1) begin
      lane_mask = lane_q[1] ? 4'b1100 : 4'b0011;
    end
  end

  assign addr_acc  = hready & htrans[1];
  assign write_acc = addr_acc & hwrite;
  assign cmd_err   = hready & ((exp_cmd0 != hcmdbpty[0]) | (exp_cmd1 != hcmdbpty[1]));
  assign addr_err  = addr_acc & (|(exp_addr ^ haddrbpty));
  assign wdata_err = (state_q == ST_WDATA) & hready & (|((exp_wdata ^ hwdatabpty) & lane_mask));
  assign err_cyc   = cmd_err | addr_err | wdata_err;

  // Data phase only advances on hready; a write accepted alongside completion reloads it.
  always_comb begin
    state_d    = state_q;
    size_d     = size_q;
    lane_d     = lane_q;
    dph_addr_d = dph_addr_q;
    if (hready) begin
      state_d = write_acc ? ST_WDATA : ST_IDLE;
    end
    if (write_acc) begin
      size_d     = hsize;
      lane_d     = addr_pad[1:0];
      dph_addr_d = haddr;
    end
  end

  // A new error outranks a same-cycle clear so it is never lost.
  always_comb begin
    err_d      = err_q;
    err_type_d = err_type_q;
    err_addr_d = err_addr_q;
    fatal_d    = err_cyc;
    if (err_cyc) begin
      if (!err_q || err_clr) begin
        err_d      = 1'b1;
        err_type_d = {wdata_err, addr_err, cmd_err};
        err_addr_d = wdata_err ? dph_addr_q : haddr;
      end
    end else if (err_clr) begin
      err_d      = 1'b0;
      err_type_d = '0;
      err_addr_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      size_q     <= '0;
      lane_q     <= '0;
      dph_addr_q <= '0;
      err_q      <= 1'b0;
      err_type_q <= '0;
      err_addr_q <= '0;
      fatal_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      size_q     <= size_d;
      lane_q     <= lane_d;
      dph_addr_q <= dph_addr_d;
      err_q      <= err_d;
      err_type_q <= err_type_d;
      err_addr_q <= err_addr_d;
      fatal_q    <= fatal_d;
    end
  end

`ifdef N101_BPTY_CHK_ERRCNT_EN
  logic [ERR_CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (err_cyc) begin
      if (err_clr) begin
        cnt_d = ERR_CNT_W'(1);
      end else if (!(&cnt_q)) begin
        cnt_d = cnt_q + ERR_CNT_W'(1);
      end
    end else if (err_clr) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bpty_err_cnt = cnt_q;
`else
  assign bpty_err_cnt = '0;
`endif

  assign bpty_err      = err_q;
  assign bpty_err_type = err_type_q;
  assign bpty_err_addr = err_addr_q;
  assign bpty_fatal    = fatal_q;

endmodule

// File: tb/tb_n101_subsys_ahb_bpty_chk.sv
// tb/tb_n101_subsys_ahb_bpty_chk.sv - directed vector bench for n101_subsys_ahb_bpty_chk
module tb_n101_subsys_ahb_bpty_chk;

`ifdef N101_BPTY_CHK_ERRCNT_EN
  localparam logic CNT_EN = 1'b1;
`else
  localparam logic CNT_EN = 1'b0;
`endif

  localparam int NV = 25;

  logic        clk = 1'b0;
  logic        rst_n, bptylvl, hwrite, hmastlock, hready, err_clr;
  logic [1:0]  htrans, master, hcmdbpty;
  logic [2:0]  hsize, hburst;
  logic [3:0]  hprot, haddrbpty, hwdatabpty;
  logic [31:0] haddr, hwdata;
  logic        bpty_err, bpty_fatal;
  logic [2:0]  bpty_err_type;
  logic [31:0] bpty_err_addr;
  logic [7:0]  bpty_err_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rst;
    logic        lvl;
    logic [1:0]  tr;
    logic [2:0]  sz;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        rdy;
    logic [1:0]  cf;
    logic [3:0]  af;
    logic [3:0]  wf;
    logic        clr;
    logic        e_err;
    logic [2:0]  e_type;
    logic [31:0] e_addr;
    logic [7:0]  e_cnt;
    logic        e_fatal;
  } vec_t;

  vec_t vecs [NV];

  n101_subsys_ahb_bpty_chk #(.ADDR_SIZE(32), .ERR_CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .bptylvl(bptylvl), .htrans(htrans), .hsize(hsize),
    .hburst(hburst), .hprot(hprot), .hwrite(hwrite), .hmastlock(hmastlock),
    .master(master), .haddr(haddr), .hwdata(hwdata), .hready(hready),
    .hcmdbpty(hcmdbpty), .haddrbpty(haddrbpty), .hwdatabpty(hwdatabpty),
    .err_clr(err_clr), .bpty_err(bpty_err), .bpty_err_type(bpty_err_type),
    .bpty_err_addr(bpty_err_addr), .bpty_err_cnt(bpty_err_cnt), .bpty_fatal(bpty_fatal)
  );

  always #5 clk = ~clk;

  function automatic vec_t v(input logic rst, input logic lvl, input logic [1:0] tr,
                             input logic [2:0] sz, input logic wr, input logic [31:0] addr,
                             input logic [31:0] wd, input logic rdy, input logic [1:0] cf,
                             input logic [3:0] af, input logic [3:0] wf, input logic clr,
                             input logic e_err, input logic [2:0] e_type,
                             input logic [31:0] e_addr, input logic [7:0] e_cnt,
                             input logic e_fatal);
    vec_t r;
    r.rst = rst; r.lvl = lvl; r.tr = tr; r.sz = sz; r.wr = wr; r.addr = addr; r.wd = wd;
    r.rdy = rdy; r.cf = cf; r.af = af; r.wf = wf; r.clr = clr;
    r.e_err = e_err; r.e_type = e_type; r.e_addr = e_addr; r.e_cnt = e_cnt; r.e_fatal = e_fatal;
    return r;
  endfunction

  function automatic logic [3:0] bpar(input logic lvl, input logic [31:0] w);
    logic [3:0] p;
    for (int b = 0; b < 4; b++) p[b] = (^w[8*b +: 8]) ^ lvl;
    return p;
  endfunction

  task automatic apply(input vec_t x);
    rst_n   = x.rst;
    bptylvl = x.lvl;
    htrans  = x.tr;
    hsize   = x.sz;
    hwrite  = x.wr;
    haddr   = x.addr;
    hwdata  = x.wd;
    hready  = x.rdy;
    err_clr = x.clr;
    hcmdbpty[0] = (^{x.tr, x.sz, hburst}) ^ x.lvl ^ x.cf[0];
    hcmdbpty[1] = (^{hprot, x.wr, hmastlock, master}) ^ x.lvl ^ x.cf[1];
    haddrbpty   = bpar(x.lvl, x.addr) ^ x.af;
    hwdatabpty  = bpar(x.lvl, x.wd) ^ x.wf;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_vec(input int i, input vec_t x);
    chk($sformatf("v%0d err", i),   32'(bpty_err),      32'(x.e_err));
    chk($sformatf("v%0d type", i),  32'(bpty_err_type), 32'(x.e_type));
    chk($sformatf("v%0d addr", i),  bpty_err_addr,      x.e_addr);
    chk($sformatf("v%0d cnt", i),   32'(bpty_err_cnt),  32'(x.e_cnt & {8{CNT_EN}}));
    chk($sformatf("v%0d fatal", i), 32'(bpty_fatal),    32'(x.e_fatal));
  endtask

  initial begin
    vec_t s;
    hburst = 3'b001; hprot = 4'b0011; hmastlock = 1'b0; master = 2'b01;
    //           rst lvl tr     sz    wr addr          wdata          rdy cf     af       wf       clr  err type    eaddr        cnt fatal
    vecs[0]  = v(0, 0, 2'b00, 3'd2, 0, 32'h0,        32'h0,         1, 2'b00, 4'b0000, 4'b0000, 0,   0, 3'b000, 32'h0,       0, 0);
    vecs[1]  = v(1, 0, 2'b00, 3'd2, 0, 32'h0,        32'h0,         1, 2'b00, 4'b0000, 4'b0000, 0,   0, 3'b000, 32'h0,       0, 0);
    vecs[2]  = v(1, 0, 2'b10, 3'd2, 0, 32'h1,        32'h0,         1, 2'b00, 4'b0001, 4'b0000, 0,   1, 3'b010, 32'h1,       1, 1);
    vecs[3]  = v(1, 0, 2'b00, 3'd2, 0, 32'h1,        32'h0,         1, 2'b00, 4'b0000, 4'b0000, 0,   1, 3'b010, 32'h1,       1, 0);
    vecs[4]  = v(1, 0, 2'b00, 3'd2, 0, 32'h1,        32'h0,         1, 2'b00, 4'b0000, 4'b0000, 1,   0, 3'b000, 32'h0,       0, 0);
    vecs[5]  = v(1, 1, 2'b10, 3'd2, 1, 32'h2000_0000, 32'h0,        1, 2'b00, 4'b0000, 4'b0000, 0,   0, 3'b000, 32'h0,       0, 0);
    vecs[6]  = v(1, 1, 2'b00, 3'd2, 0, 32'h2000_0000, 32'hFF00_0001, 0, 2'b00, 4'b0000, 4'b1111, 0,  0, 3'b000, 32'h0,       0, 0);
    vecs[7]  = v(1, 1, 2'b00, 3'd2, 0, 32'h2000_0000, 32'hFF00_0001, 1, 2'b00, 4'b0000, 4'b0000, 0,  0, 3'b000, 32'h0,       0, 0);
    vecs[8]  = v(1, 0, 2'b10, 3'd0, 1, 32'h1002,     32'h0,         1, 2'b00, 4'b0000, 4'b0000, 0,   0, 3'b000, 32'h0,       0, 0);
    vecs[9]  = v(1, 0, 2'b00, 3'd2, 0, 32'h1002,     32'h0012_0000, 1, 2'b00, 4'b0000, 4'b1011, 0,   0, 3'b000, 32'h0,       0, 0);
    vecs[10] = v(1, 0, 2'b10, 3'd0, 1, 32'h1002,     32'h0,         1, 2'b00, 4'b0000, 4'b0000, 0,   0, 3'b000, 32'h0,       0, 0);
    vecs[11] = v(1, 0, 2'b00, 3'd2, 0, 32'h5555,     32'h0012_0000, 1, 2'b00, 4'b0000, 4'b0100, 0,   1, 3'b100, 32'h1002,    1, 1);
    vecs[12] = v(1, 0, 2'b00, 3'd2, 0, 32'h0,        32'h0,         1, 2'b00, 4'b0000, 4'b0000, 1,   0, 3'b000, 32'h0,       0, 0);
    vecs[13] = v(1, 0, 2'b10, 3'd1, 1, 32'h40,       32'h0,         1, 2'b01, 4'b0010, 4'b0000, 0,   1, 3'b011, 32'h40,      1, 1);
    vecs[14] = v(1, 0, 2'b00, 3'd2, 0, 32'h40,       32'h0,         0, 2'b00, 4'b0000, 4'b0010, 0,   1, 3'b011, 32'h40,      1, 0);
    vecs[15] = v(1, 0, 2'b00, 3'd2, 0, 32'h40,       32'h0,         1, 2'b00, 4'b0000, 4'b0010, 0,   1, 3'b011, 32'h40,      2, 1);
    vecs[16] = v(1, 0, 2'b10, 3'd1, 1, 32'h42,       32'h0,         1, 2'b00, 4'b0000, 4'b0000, 1,   0, 3'b000, 32'h0,       0, 0);
    vecs[17] = v(1, 0, 2'b10, 3'd2, 1, 32'h80,       32'h0,         1, 2'b00, 4'b0000, 4'b0011, 0,   0, 3'b000, 32'h0,       0, 0);
    vecs[18] = v(1, 0, 2'b10, 3'd2, 0, 32'hC0,       32'h0,         1, 2'b00, 4'b0000, 4'b1000, 0,   1, 3'b100, 32'h80,      1, 1);
    vecs[19] = v(1, 0, 2'b00, 3'd2, 0, 32'hC0,       32'h0,         1, 2'b00, 4'b0000, 4'b1111, 0,   1, 3'b100, 32'h80,      1, 0);
    vecs[20] = v(1, 0, 2'b00, 3'd2, 0, 32'h100,      32'h0,         1, 2'b10, 4'b0000, 4'b0000, 1,   1, 3'b001, 32'h100,     1, 1);
    vecs[21] = v(1, 0, 2'b00, 3'd2, 0, 32'h100,      32'h0,         0, 2'b10, 4'b0000, 4'b0000, 0,   1, 3'b001, 32'h100,     1, 0);
    vecs[22] = v(1, 0, 2'b10, 3'd2, 1, 32'h200,      32'h0,         1, 2'b00, 4'b0000, 4'b0000, 1,   0, 3'b000, 32'h0,       0, 0);
    vecs[23] = v(0, 0, 2'b00, 3'd2, 0, 32'h200,      32'h1234_5678, 1, 2'b00, 4'b0000, 4'b1111, 0,   0, 3'b000, 32'h0,       0, 0);
    vecs[24] = v(1, 0, 2'b00, 3'd2, 0, 32'h200,      32'h1234_5678, 1, 2'b00, 4'b0000, 4'b1111, 0,   0, 3'b000, 32'h0,       0, 0);

    apply(vecs[0]);
    for (int i = 0; i < NV; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk_vec(i, vecs[i]);
      if (i + 1 < NV) apply(vecs[i + 1]);
    end

    // 300 back-to-back command errors: fatal stays high, counter saturates.
    s = v(1, 0, 2'b00, 3'd2, 0, 32'h300, 32'h0, 1, 2'b01, 4'b0000, 4'b0000, 0,
          1, 3'b001, 32'h300, 8'hFF, 1);
    apply(s);
    for (int k = 0; k < 300; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("sat%0d fatal", k), 32'(bpty_fatal), 32'h1);
    end
    chk_vec(100, s);
    s.cf = 2'b00;
    s.e_fatal = 1'b0;
    apply(s);
    @(posedge clk);
    @(negedge clk);
    chk_vec(101, s);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
